// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe: valid/ready on the operand side and on the result side.
interface addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovfl, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovfl, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: one GRP_W-bit group per stage, carry rippling stage to stage,
// with per-stage valid bits, backpressure, flags and optional signed saturation.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GRP_W = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave io_bus
);
  localparam int NGRP = WIDTH / GRP_W;

  if ((GRP_W < 1) || ((WIDTH % GRP_W) != 0)) begin : g_param_chk
    $error("addsub_pipe: WIDTH must be a positive multiple of GRP_W");
  end

  function automatic logic [GRP_W:0] grp_add(input logic [GRP_W-1:0] x,
                                             input logic [GRP_W-1:0] y,
                                             input logic             c);
    grp_add = {1'b0, x} + {1'b0, y} + {{GRP_W{1'b0}}, c};
  endfunction

  // Element k is what enters stage k: full skewed operands, partial sum, carry, valid.
  logic [WIDTH-1:0] w_a [NGRP];
  logic [WIDTH-1:0] w_b [NGRP];
  logic [WIDTH-1:0] w_s [NGRP];
  logic [NGRP-1:0]  w_c;
  logic [NGRP-1:0]  w_v;
  logic [NGRP-1:0]  w_vreg;
  logic [NGRP-1:0]  w_en;

  assign w_a[0] = io_bus.a;
  assign w_b[0] = io_bus.sub ? ~io_bus.b : io_bus.b;
  assign w_c[0] = io_bus.sub ? 1'b1 : io_bus.cin;
  assign w_s[0] = {WIDTH{1'b0}};
  assign w_v[0] = io_bus.in_valid;

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic w_acc;
    w_acc = io_bus.out_ready;
    w_en  = {NGRP{1'b0}};
    for (int k = NGRP - 1; k >= 0; k--) begin
      w_acc   = ~w_vreg[k] | w_acc;
      w_en[k] = w_acc;
    end
  end

  assign io_bus.in_ready = w_en[0];

  for (genvar k = 0; k < NGRP; k++) begin : g_stg
    logic [GRP_W:0]   w_grp;
    logic [WIDTH-1:0] w_snew;

    assign w_grp = grp_add(w_a[k][k*GRP_W +: GRP_W], w_b[k][k*GRP_W +: GRP_W], w_c[k]);

    // Merge this stage's group result into the partial sum.
    always_comb begin
      w_snew                     = w_s[k];
      w_snew[k*GRP_W +: GRP_W]   = w_grp[GRP_W-1:0];
    end

    if (k < NGRP - 1) begin : g_mid
      logic             r_v;
      logic             r_c;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;

      // Stage valid bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (w_en[k]) begin
          r_v <= w_v[k];
        end
      end

      // Skewed datapath, no reset needed.
      always_ff @(posedge clk) begin
        if (w_en[k]) begin
          r_a <= w_a[k];
          r_b <= w_b[k];
          r_s <= w_snew;
          r_c <= w_grp[GRP_W];
        end
      end

      assign w_a[k+1]  = r_a;
      assign w_b[k+1]  = r_b;
      assign w_s[k+1]  = r_s;
      assign w_c[k+1]  = r_c;
      assign w_v[k+1]  = r_v;
      assign w_vreg[k] = r_v;
    end else begin : g_last
      logic             w_am;
      logic             w_bm;
      logic             w_ovfl;
      logic [WIDTH-1:0] w_res;
      logic             r_v;
      logic [WIDTH-1:0] r_sum;
      logic             r_cout;
      logic             r_ovfl;
      logic             r_zero;
      logic             r_neg;

      assign w_am   = w_a[k][WIDTH-1];
      assign w_bm   = w_b[k][WIDTH-1];
      assign w_ovfl = (w_am == w_bm) & (w_snew[WIDTH-1] != w_am);

      // Clamp toward the sign of the operands on signed overflow.
      always_comb begin
        if ((SAT == 1'b1) && w_ovfl) begin
          w_res = w_am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          w_res = w_snew;
        end
      end

      // Output register; a bubble clears the result so idle outputs read zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v    <= 1'b0;
          r_sum  <= {WIDTH{1'b0}};
          r_cout <= 1'b0;
          r_ovfl <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_en[k]) begin
          r_v <= w_v[k];
          if (w_v[k]) begin
            r_sum  <= w_res;
            r_cout <= w_grp[GRP_W];
            r_ovfl <= w_ovfl;
            r_zero <= (w_res == {WIDTH{1'b0}});
            r_neg  <= w_res[WIDTH-1];
          end else begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
            r_ovfl <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
          end
        end
      end

      assign w_vreg[k]        = r_v;
      assign io_bus.out_valid = r_v;
      assign io_bus.sum       = r_sum;
      assign io_bus.cout      = r_cout;
      assign io_bus.ovfl      = r_ovfl;
      assign io_bus.zero      = r_zero;
      assign io_bus.neg       = r_neg;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: a wrapping and a saturating instance share one stimulus stream.
module tb_addsub_pipe;
  localparam int W = 16;
  localparam int G = 4;
  localparam int N = W / G;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic        zero;
    logic        neg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_in_valid = 1'b0;
  logic        t_sub = 1'b0;
  logic        t_cin = 1'b0;
  logic        t_out_ready = 1'b0;
  logic [15:0] t_a = 16'd0;
  logic [15:0] t_b = 16'd0;
  bit          rnd_ready = 1'b0;
  int          total = 0;
  int          bad = 0;
  res_t        q0[$];
  res_t        q1[$];
  res_t        w_res0;
  res_t        w_res1;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W)) bus0 ();
  addsub_pipe_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid  = t_in_valid;
  assign bus0.a         = t_a;
  assign bus0.b         = t_b;
  assign bus0.sub       = t_sub;
  assign bus0.cin       = t_cin;
  assign bus0.out_ready = t_out_ready;
  assign bus1.in_valid  = t_in_valid;
  assign bus1.a         = t_a;
  assign bus1.b         = t_b;
  assign bus1.sub       = t_sub;
  assign bus1.cin       = t_cin;
  assign bus1.out_ready = t_out_ready;

  assign w_res0 = {bus0.sum, bus0.cout, bus0.ovfl, bus0.zero, bus0.neg};
  assign w_res1 = {bus1.sum, bus1.cout, bus1.ovfl, bus1.zero, bus1.neg};

  addsub_pipe #(.WIDTH(W), .GRP_W(G), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .io_bus(bus0));
  addsub_pipe #(.WIDTH(W), .GRP_W(G), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .io_bus(bus1));

  // Reference: plain integer arithmetic on the operands as numbers.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin, input bit sat);
    int   ua, ub, sa, sb, t;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sub ? (sa - sb) : (sa + sb + int'(cin));
    r.cout = sub ? (ua >= ub) : ((ua + ub + int'(cin)) > 65535);
    r.ovfl = (t > 32767) || (t < -32768);
    if (sat && r.ovfl) r.sum = (t > 0) ? 16'h7FFF : 16'h8000;
    else               r.sum = t[15:0];
    r.zero = (r.sum == 16'h0000);
    r.neg  = r.sum[15];
    return r;
  endfunction

  function automatic logic [31:0] pk(input logic [15:0] s, input logic c, input logic o,
                                     input logic z, input logic ng);
    return {12'd0, s, c, o, z, ng};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: in_ready against in-flight count, results against queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("in_ready", {31'd0, bus0.in_ready}, {31'd0, !((q0.size() == N) && !t_out_ready)});
      chk("in_ready sat", {31'd0, bus1.in_ready}, {31'd0, !((q1.size() == N) && !t_out_ready)});
      if (bus0.out_valid && t_out_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0 extra beat: got %h want none", w_res0);
        end else chk("dut0 result", {12'd0, w_res0}, {12'd0, q0.pop_front()});
      end
      if (bus1.out_valid && t_out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1 extra beat: got %h want none", w_res1);
        end else chk("dut1 result", {12'd0, w_res1}, {12'd0, q1.pop_front()});
      end
      if (t_in_valid && bus0.in_ready) begin
        q0.push_back(model(t_a, t_b, t_sub, t_cin, 1'b0));
        q1.push_back(model(t_a, t_b, t_sub, t_cin, 1'b1));
      end
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+2 after acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    bit ok;
    ok = 1'b0;
    t_a = a; t_b = b; t_sub = sub; t_cin = cin; t_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rnd_ready) t_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept timeout: got no in_ready want in_ready");
    end
    @(posedge clk); #2;
    t_in_valid = 1'b0;
  endtask

  // Count negedges until out_valid; n stays 0 if it never shows.
  task automatic wait_out(output int n, output res_t r0, output res_t r1);
    n = 0; r0 = '0; r1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus0.out_valid) begin
        n = i; r0 = w_res0; r1 = w_res1;
        break;
      end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    res_t        r0, r1, hold;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [5:0]  pat;

    #1;
    chk("reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("reset outputs", {12'd0, w_res0}, 32'd0);
    chk("reset outputs sat", {12'd0, w_res1}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", {31'd0, bus0.in_ready}, 32'd1);
    @(posedge clk); #2;
    t_out_ready = 1'b1;

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n, r0, r1);
    chk("latency", n, N);
    chk("7fff+1 wrap", {12'd0, r0}, pk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
    chk("7fff+1 sat", {12'd0, r1}, pk(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_out(n, r0, r1);
    chk("8000-1 wrap", {12'd0, r0}, pk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("8000-1 sat", {12'd0, r1}, pk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(n, r0, r1);
    chk("ffff+1", {12'd0, r0}, pk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    send(16'h0005, 16'h0005, 1'b1, 1'b0);
    wait_out(n, r0, r1);
    chk("5-5", {12'd0, r0}, pk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    chk("5-5 sat", {12'd0, r1}, pk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));

    rnd_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rnd_ready = 1'b0;
    t_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q0.size() == 0) break;
    end
    @(posedge clk); #2;
    chk("random drained", 32'(q0.size()), 32'd0);

    t_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      send(va[i], vb[i], 1'b0, 1'b1);
    end
    hold = model(va[0], vb[0], 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall held", {12'd0, w_res0}, {12'd0, hold});
      chk("stall out_valid", {31'd0, bus0.out_valid}, 32'd1);
      chk("stall in_ready", {31'd0, bus0.in_ready}, 32'd0);
    end
    chk("held count", 32'(q0.size()), 32'd4);
    @(posedge clk); #2;
    t_out_ready = 1'b1;
    pat = 6'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = {pat[4:0], bus0.out_valid};
    end
    chk("drain pattern", {26'd0, pat}, {26'd0, 6'b111100});
    @(posedge clk); #2;

    t_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("pre-reset out_valid", {31'd0, bus0.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("mid reset outputs", {12'd0, w_res0}, 32'd0);
    chk("mid reset outputs sat", {12'd0, w_res1}, 32'd0);
    t_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no stale beat", {31'd0, bus0.out_valid}, 32'd0);
    end
    @(posedge clk); #2;
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_out(n, r0, r1);
    chk("post-reset latency", n, N);
    chk("post-reset result", {12'd0, r0}, pk(16'h5556, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("post-reset result sat", {12'd0, r1}, pk(16'h5556, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    chk("final queue0", 32'(q0.size()), 32'd0);
    chk("final queue1", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
